// File: rtl/ddr_port_arbiter.sv
// Shares the MIG user port between wfc/bfc/dfc readers and the write-back unit.
// Define ARB_FIXED_PRIORITY_EN for fixed priority dfc > wfc > bfc > wb; otherwise round-robin.
module ddr_port_arbiter #(
    parameter int DDR_ADDR_LEN = 32,
    parameter int SINGLE_LEN   = 24,
    parameter int BURST_BYTES  = 64
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [3:0]                req,
    input  logic [4*DDR_ADDR_LEN-1:0] req_addr,
    input  logic [4*SINGLE_LEN-1:0]   req_bytes,
    output logic [3:0]                gnt,
    output logic [3:0]                done,
    output logic [1:0]                switch,
    output logic                      mig_type,
    output logic                      app_en,
    output logic [2:0]                app_cmd,
    output logic [DDR_ADDR_LEN-1:0]   app_addr,
    input  logic                      app_rdy,
    input  logic                      app_rd_data_valid,
    input  logic                      app_wdf_wren,
    input  logic                      app_wdf_rdy
);

    localparam int BURST_SHIFT = $clog2(BURST_BYTES);
    localparam logic [SINGLE_LEN-1:0]   CNT_ONE   = SINGLE_LEN'(1);
    localparam logic [DDR_ADDR_LEN-1:0] ADDR_STEP = DDR_ADDR_LEN'(BURST_BYTES);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ARB   = 3'd1,
        CMD   = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t                  state_reg;
    logic [1:0]              owner_reg;
    logic [3:0]              gnt_reg;
    logic [3:0]              done_reg;
    logic [1:0]              switch_reg;
    logic                    mig_type_reg;
    logic                    app_en_reg;
    logic [2:0]              app_cmd_reg;
    logic [DDR_ADDR_LEN-1:0] app_addr_reg;
    logic [SINGLE_LEN-1:0]   cmds_reg;
    logic [SINGLE_LEN-1:0]   cmd_cnt_reg;
    logic [SINGLE_LEN-1:0]   beat_cnt_reg;

    logic [DDR_ADDR_LEN-1:0] addr_arr  [4];
    logic [SINGLE_LEN-1:0]   bytes_arr [4];

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_unpack
            assign addr_arr[gi]  = req_addr[gi*DDR_ADDR_LEN +: DDR_ADDR_LEN];
            assign bytes_arr[gi] = req_bytes[gi*SINGLE_LEN +: SINGLE_LEN];
        end
    endgenerate

    logic       win_valid;
    logic [1:0] win_idx;

`ifdef ARB_FIXED_PRIORITY_EN
    // Later assignments override earlier ones, so the last test is the highest priority.
    always_comb begin
        win_valid = |req;
        win_idx   = 2'd3;
        if (req[1]) win_idx = 2'd1;
        if (req[0]) win_idx = 2'd0;
        if (req[2]) win_idx = 2'd2;
    end
`else
    logic [1:0] last_owner_reg;
    logic [1:0] cand;

    // Scan from furthest to nearest so the requester right after the last owner wins.
    always_comb begin
        win_valid = 1'b0;
        win_idx   = 2'd0;
        cand      = 2'd0;
        for (int k = 4; k >= 1; k--) begin
            cand = last_owner_reg + 2'(k);
            if (req[cand]) begin
                win_valid = 1'b1;
                win_idx   = cand;
            end
        end
    end
`endif

    logic [SINGLE_LEN:0]   bytes_round;
    logic [SINGLE_LEN-1:0] cmds_next;
    logic                  beat;
    logic                  last_accept;

    assign bytes_round = {1'b0, bytes_arr[win_idx]} + (SINGLE_LEN+1)'(BURST_BYTES - 1);
    assign cmds_next   = SINGLE_LEN'(bytes_round >> BURST_SHIFT);
    assign beat        = mig_type_reg ? (app_wdf_wren & app_wdf_rdy) : app_rd_data_valid;
    assign last_accept = (cmd_cnt_reg + CNT_ONE) == cmds_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            owner_reg      <= 2'd0;
            gnt_reg        <= 4'd0;
            done_reg       <= 4'd0;
            switch_reg     <= 2'd0;
            mig_type_reg   <= 1'b0;
            app_en_reg     <= 1'b0;
            app_cmd_reg    <= 3'd0;
            app_addr_reg   <= '0;
            cmds_reg       <= '0;
            cmd_cnt_reg    <= '0;
            beat_cnt_reg   <= '0;
`ifndef ARB_FIXED_PRIORITY_EN
            last_owner_reg <= 2'd3;
`endif
        end else begin
            case (state_reg)
                IDLE: begin
                    if (|req) state_reg <= ARB;
                end
                ARB: begin
                    if (win_valid) begin
                        owner_reg    <= win_idx;
                        gnt_reg      <= 4'b0001 << win_idx;
                        switch_reg   <= win_idx + 2'd1;
                        mig_type_reg <= (win_idx == 2'd3);
                        app_cmd_reg  <= (win_idx == 2'd3) ? 3'b000 : 3'b001;
                        app_addr_reg <= addr_arr[win_idx];
                        cmds_reg     <= cmds_next;
                        cmd_cnt_reg  <= '0;
                        beat_cnt_reg <= '0;
                        if (cmds_next == '0) begin
                            state_reg <= DONE;
                            done_reg  <= 4'b0001 << win_idx;
                        end else begin
                            state_reg <= CMD;
                        end
                    end else begin
                        state_reg <= IDLE;
                    end
                end
                CMD: begin
                    if (beat) beat_cnt_reg <= beat_cnt_reg + CNT_ONE;
                    // First CMD cycle only raises app_en; accepts are counted from then on.
                    if (!app_en_reg) begin
                        app_en_reg <= 1'b1;
                    end else if (app_rdy) begin
                        app_addr_reg <= app_addr_reg + ADDR_STEP;
                        cmd_cnt_reg  <= cmd_cnt_reg + CNT_ONE;
                        if (last_accept) begin
                            app_en_reg <= 1'b0;
                            state_reg  <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (beat) beat_cnt_reg <= beat_cnt_reg + CNT_ONE;
                    if (beat_cnt_reg == cmds_reg) begin
                        state_reg <= DONE;
                        done_reg  <= 4'b0001 << owner_reg;
                    end
                end
                DONE: begin
                    done_reg       <= 4'd0;
                    gnt_reg        <= 4'd0;
`ifndef ARB_FIXED_PRIORITY_EN
                    last_owner_reg <= owner_reg;
`endif
                    state_reg      <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign gnt      = gnt_reg;
    assign done     = done_reg;
    assign switch   = switch_reg;
    assign mig_type = mig_type_reg;
    assign app_en   = app_en_reg;
    assign app_cmd  = app_cmd_reg;
    assign app_addr = app_addr_reg;

`ifndef SYNTHESIS
    // Owners must hold req until their done pulse.
    a_req_held: assert property (@(posedge clk) disable iff (!rst_n)
        ((gnt_reg & ~req & ~done_reg) == 4'd0));
`endif

endmodule
